// File: rtl/spi_slave_pkg.sv
// Shared types and header layout helpers for the parametrised SPI register-bank slave.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2
    } state_e;

    // Header bit positions in capture order: WR | DEV_ADDR | BURST | REG_ADDR
    localparam int WR_OFS  = 0;
    localparam int DEV_OFS = 1;

    function automatic int burst_ofs(input int dev_aw);
        return 1 + dev_aw;
    endfunction

    function automatic int reg_ofs(input int dev_aw);
        return 2 + dev_aw;
    endfunction

    function automatic int hdr_len(input int dev_aw, input int reg_aw);
        return 2 + dev_aw + reg_aw;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Register storage: sync clear, one write port, combinational read (out of range reads 0).
module spi_reg_bank
    import spi_slave_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       we,
    input  logic [REG_AW-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [REG_AW-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == REG_AW'(i)) mem_q[i] <= wdata;
            end
        end
    end

    // Addresses without a matching entry fall through to the zero default.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == REG_AW'(i)) rdata = mem_q[i];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*DATA_W +: DATA_W] = mem_q[gi];
        end
    endgenerate

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave front end: header decode, data shifter and frame FSM around spi_reg_bank.
module spi_slave_regbank
    import spi_slave_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    parameter  int DEV_AW   = 3,
    parameter  int DATA_MSB = 0,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       cs,
    input  logic                       mosi,
    input  logic [DEV_AW-1:0]          addr,
    output logic                       miso,
    output logic                       miso_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_stb,
    output logic [REG_AW-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       frame_err
);

    localparam int HDR_LEN   = hdr_len(DEV_AW, REG_AW);
    localparam int BURST_OFS = burst_ofs(DEV_AW);
    localparam int REG_OFS   = reg_ofs(DEV_AW);
    localparam int CNT_MAX   = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HDR_LEN-1:0]  hdr_q, hdr_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d;
    logic                is_wr_q, is_wr_d;
    logic                burst_q, burst_d;
    logic                match_q, match_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                wr_stb_q, wr_stb_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                frame_err_q, frame_err_d;

    logic [HDR_LEN-1:0]  hdr_shift;
    logic [DEV_AW-1:0]   hdr_dev;
    logic [REG_AW-1:0]   hdr_reg;
    logic                hdr_wr, hdr_burst, hdr_match;
    logic [DATA_W-1:0]   word_in, sh_adv, rd_data;
    logic [REG_AW-1:0]   ptr_inc, rd_addr;
    logic                ptr_in_range, bank_we;

    function automatic logic lead_bit(input logic [DATA_W-1:0] w);
        return (DATA_MSB != 0) ? w[DATA_W-1] : w[0];
    endfunction

    // Header arrives LSB first, so new bits enter at the top and settle at their offsets.
    assign hdr_shift = {mosi, hdr_q[HDR_LEN-1:1]};
    assign hdr_wr    = hdr_shift[WR_OFS];
    assign hdr_dev   = hdr_shift[DEV_OFS +: DEV_AW];
    assign hdr_burst = hdr_shift[BURST_OFS];
    assign hdr_reg   = hdr_shift[REG_OFS +: REG_AW];
    assign hdr_match = (hdr_dev == addr);

    assign word_in = (DATA_MSB != 0) ? {sh_q[DATA_W-2:0], mosi} : {mosi, sh_q[DATA_W-1:1]};
    assign sh_adv  = (DATA_MSB != 0) ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

    assign ptr_inc      = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign rd_addr      = (state_q == HDR) ? hdr_reg : ptr_inc;
    assign ptr_in_range = 32'(ptr_q) < NUM_REGS;

    spi_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk       (sclk),
        .srst      (rst),
        .we        (bank_we),
        .waddr     (ptr_q),
        .wdata     (word_in),
        .raddr     (rd_addr),
        .rdata     (rd_data),
        .regs_flat (regs_flat)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hdr_d       = hdr_q;
        sh_d        = sh_q;
        ptr_d       = ptr_q;
        is_wr_d     = is_wr_q;
        burst_d     = burst_q;
        match_d     = match_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        bank_we     = 1'b0;

        if (!cs) begin
            state_d     = HDR;
            bit_cnt_d   = '0;
            miso_d      = 1'b0;
            oe_d        = 1'b0;
            frame_err_d = (state_q == DATA) && (bit_cnt_q != '0);
        end else begin
            case (state_q)
                HDR: begin
                    hdr_d     = hdr_shift;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(HDR_LEN - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        is_wr_d   = hdr_wr;
                        burst_d   = hdr_burst;
                        ptr_d     = hdr_reg;
                        match_d   = hdr_match;
                        if (!hdr_wr && hdr_match) begin
                            sh_d   = rd_data;
                            miso_d = lead_bit(rd_data);
                            oe_d   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (is_wr_q) begin
                        sh_d = word_in;
                    end else begin
                        sh_d   = sh_adv;
                        miso_d = match_q & lead_bit(sh_adv);
                    end
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        ptr_d     = ptr_inc;
                        if (is_wr_q && match_q && ptr_in_range) begin
                            bank_we   = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = word_in;
                        end
                        if (!burst_q) begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                            oe_d    = 1'b0;
                        end else if (!is_wr_q && match_q) begin
                            sh_d   = rd_data;
                            miso_d = lead_bit(rd_data);
                        end
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
                default: begin
                    state_d   = HDR;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= HDR;
            bit_cnt_q   <= '0;
            hdr_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            is_wr_q     <= 1'b0;
            burst_q     <= 1'b0;
            match_q     <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hdr_q       <= hdr_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            is_wr_q     <= is_wr_d;
            burst_q     <= burst_d;
            match_q     <= match_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = oe_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench: default 8x8 slave plus a NUM_REGS=5 instance sharing the same SPI bus.
module tb_spi_slave_regbank;

    logic        sclk = 1'b0;
    logic        rst, cs, mosi;
    logic [2:0]  addr;

    logic        miso, miso_oe, wr_stb, frame_err;
    logic [63:0] regs_flat;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    logic        miso5, miso_oe5, wr_stb5, frame_err5;
    logic [39:0] regs_flat5;
    logic [2:0]  wr_addr5;
    logic [7:0]  wr_data5;

    int n_vec = 0;
    int n_bad = 0;
    int stb_cnt, oe_cnt, ferr_cnt, stb5_cnt, oe5_cnt, leak_cnt;
    logic [2:0] last_waddr;
    logic [7:0] last_wdata;
    logic [7:0] d0, d5;

    always #5 sclk = ~sclk;

    spi_slave_regbank #(
        .DATA_W(8), .NUM_REGS(8), .DEV_AW(3), .DATA_MSB(0)
    ) u_dut (
        .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi), .addr(addr),
        .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    spi_slave_regbank #(
        .DATA_W(8), .NUM_REGS(5), .DEV_AW(3), .DATA_MSB(0)
    ) u_dut5 (
        .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi), .addr(addr),
        .miso(miso5), .miso_oe(miso_oe5), .regs_flat(regs_flat5),
        .wr_stb(wr_stb5), .wr_addr(wr_addr5), .wr_data(wr_data5), .frame_err(frame_err5)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        stb_cnt  = 0; oe_cnt  = 0; ferr_cnt = 0;
        stb5_cnt = 0; oe5_cnt = 0;
    endtask

    task automatic sample();
        if (wr_stb) begin
            stb_cnt++;
            last_waddr = wr_addr;
            last_wdata = wr_data;
        end
        if (miso_oe)   oe_cnt++;
        if (frame_err) ferr_cnt++;
        if (wr_stb5)   stb5_cnt++;
        if (miso_oe5)  oe5_cnt++;
        if ((!miso_oe && miso) || (!miso_oe5 && miso5)) leak_cnt++;
    endtask

    task automatic bit_edge(input logic m);
        cs = 1'b1;
        mosi = m;
        @(posedge sclk);
        #1;
        sample();
    endtask

    task automatic idle_edge();
        cs = 1'b0;
        mosi = 1'b0;
        @(posedge sclk);
        #1;
        sample();
    endtask

    task automatic send_hdr(input logic wr, input logic [2:0] dev, input logic burst,
                            input logic [2:0] rg);
        bit_edge(wr);
        for (int i = 0; i < 3; i++) bit_edge(dev[i]);
        bit_edge(burst);
        for (int i = 0; i < 3; i++) bit_edge(rg[i]);
    endtask

    task automatic send_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) bit_edge(d[i]);
    endtask

    task automatic read_word(output logic [7:0] d, output logic [7:0] e);
        for (int i = 0; i < 8; i++) begin
            d[i] = miso;
            e[i] = miso5;
            bit_edge(1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cs = 1'b0; mosi = 1'b0; addr = 3'b101;
        leak_cnt = 0;
        clear_counts();
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_regs", regs_flat, 64'h0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_miso", miso, 0);
        chk("rst_stb", wr_stb, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;
        idle_edge();

        // Single write of 0xA5 to reg 2
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b0, 3'd2);
        send_word(8'hA5);
        chk("w1_stb_cnt", stb_cnt, 1);
        chk("w1_waddr", last_waddr, 2);
        chk("w1_wdata", last_wdata, 8'hA5);
        idle_edge();
        chk("w1_oe_cnt", oe_cnt, 0);
        chk("w1_regs", regs_flat, 64'h0000000000A50000);

        // Read reg 2: eight output cycles, then quiet in DONE
        clear_counts();
        send_hdr(1'b0, 3'd5, 1'b0, 3'd2);
        chk("r1_oe_first", miso_oe, 1);
        read_word(d0, d5);
        chk("r1_data", d0, 8'hA5);
        chk("r1_oe_cnt", oe_cnt, 8);
        chk("r1_done_oe", miso_oe, 0);
        bit_edge(1'b1);
        chk("r1_done_hold", miso_oe, 0);
        chk("r1_stb_cnt", stb_cnt, 0);
        idle_edge();

        // Burst write from 7 wraps to 0 and 1
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b1, 3'd7);
        send_word(8'h11);
        chk("bw_addr0", last_waddr, 7);
        send_word(8'h22);
        chk("bw_addr1", last_waddr, 0);
        send_word(8'h33);
        chk("bw_addr2", last_waddr, 1);
        chk("bw_data2", last_wdata, 8'h33);
        idle_edge();
        chk("bw_stb_cnt", stb_cnt, 3);
        chk("bw_ferr", ferr_cnt, 0);
        chk("bw_regs", regs_flat, 64'h1100000000A53322);

        // Frames to another device are ignored
        clear_counts();
        send_hdr(1'b1, 3'd4, 1'b0, 3'd3);
        send_word(8'hFF);
        idle_edge();
        send_hdr(1'b0, 3'd4, 1'b0, 3'd2);
        read_word(d0, d5);
        idle_edge();
        chk("nm_oe_cnt", oe_cnt, 0);
        chk("nm_stb_cnt", stb_cnt, 0);
        chk("nm_regs", regs_flat, 64'h1100000000A53322);

        // Aborted write after 5 data bits, then a clean frame
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b0, 3'd4);
        for (int i = 0; i < 5; i++) bit_edge(1'b1);
        idle_edge();
        chk("ab_ferr_now", frame_err, 1);
        chk("ab_ferr_cnt", ferr_cnt, 1);
        chk("ab_stb_cnt", stb_cnt, 0);
        chk("ab_regs", regs_flat, 64'h1100000000A53322);
        idle_edge();
        chk("ab_ferr_gone", frame_err, 0);
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b0, 3'd4);
        send_word(8'h3C);
        idle_edge();
        chk("ab_next_stb", stb_cnt, 1);
        chk("ab_next_regs", regs_flat, 64'h1100003C00A53322);

        // Burst read from 7 across the wrap, then reset mid-word
        clear_counts();
        send_hdr(1'b0, 3'd5, 1'b1, 3'd7);
        read_word(d0, d5);
        chk("br_w0", d0, 8'h11);
        read_word(d0, d5);
        chk("br_w1", d0, 8'h22);
        read_word(d0, d5);
        chk("br_w2", d0, 8'h33);
        chk("br_oe_held", miso_oe, 1);
        for (int i = 0; i < 3; i++) bit_edge(1'b0);
        rst = 1'b1;
        @(posedge sclk);
        #1;
        chk("rs_regs", regs_flat, 64'h0);
        chk("rs_oe", miso_oe, 0);
        chk("rs_miso", miso, 0);
        chk("rs_ferr", frame_err, 0);
        chk("rs_regs5", regs_flat5, 40'h0);
        rst = 1'b0;
        idle_edge();

        // Out-of-range register on the 5-entry bank
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b0, 3'd6);
        send_word(8'h5A);
        idle_edge();
        chk("oor_stb", stb_cnt, 1);
        chk("oor_stb5", stb5_cnt, 0);
        clear_counts();
        send_hdr(1'b0, 3'd5, 1'b0, 3'd6);
        read_word(d0, d5);
        idle_edge();
        chk("oor_rd", d0, 8'h5A);
        chk("oor_rd5", d5, 8'h00);
        chk("oor_oe5", oe5_cnt, 8);

        // Burst write from the last entry of the 5-entry bank wraps to 0
        clear_counts();
        send_hdr(1'b1, 3'd5, 1'b1, 3'd4);
        send_word(8'h77);
        send_word(8'h88);
        idle_edge();
        chk("w5_stb5", stb5_cnt, 2);
        chk("w5_regs5", regs_flat5, 40'h7700000088);
        chk("w5_regs", regs_flat, 64'h005A887700000000);

        chk("miso_leak", leak_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
